fetch_stage: RTL and testbench
==============================

# fetch_stage

Parametrised LEGv8 instruction-fetch stage with an integrated IF/ID pipeline register. It drives a variable-latency instruction memory through a req/ready handshake and supports stall, decode flush, and redirect by branch or exception vector. A redirect that arrives while a fetch is in flight is absorbed without corrupting the stream. It sits between the PC-select logic of the pipelined core and the decode stage.

## Interface
- `N`, 64: PC/address width.
- `INSN_W`, 32: instruction width.
- `RESET_PC`, 0: PC after reset.
- `EXC_VECTOR`, 64'hD8: exception redirect target.
- `PC_STEP`, 4: sequential increment.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `PCSrc_F` input 1: take branch redirect to `PCBranch_F` this cycle.
- `PCBranch_F` input N: branch target.
- `Exc_F` input 1: take exception redirect to `EXC_VECTOR`; overrides `PCSrc_F`.
- `Stall_F` input 1: hold the IF/ID register.
- `Flush_D` input 1: insert a bubble into IF/ID.
- `imem_req_F` output 1: fetch request.
- `imem_addr_F` output N: fetch address (= PC register).
- `imem_ready_F` input 1: response valid; qualifies `imem_data_F`.
- `imem_data_F` input INSN_W: fetched instruction.
- `instr_D` output INSN_W: IF/ID instruction.
- `pc_D` output N: IF/ID PC.
- `valid_D` output 1: IF/ID entry valid.

## Operation
- **Memory protocol.** While `imem_req_F`=1, `imem_addr_F` is held stable until a cycle with `imem_ready_F`=1. A request is never withdrawn. Latency is ≥0 cycles; ready may arrive in the same cycle as the request.
- **Event priority:** reset > `Exc_F` > `PCSrc_F` > `Stall_F`.
- **Redirect target:** `EXC_VECTOR` if `Exc_F`=1, else `PCBranch_F`.
- **FSM states:**
  - BOOT: req=0.
  - RUN: req=1, address = PC.
  - KILL: req=1, old address held; the response will be discarded.
  - HOLD: req=0; a response is parked in a one-entry buffer.
- **BOOT:** unconditionally goes to RUN next cycle.
- **RUN, redirect, ready=1:** response discarded; PC←target; stay RUN.
- **RUN, redirect, ready=0:** pending←target; go KILL.
- **RUN, ready=1, no redirect, !Stall_F:** IF/ID←{data, PC, 1}; PC←PC+PC_STEP.
- **RUN, ready=1, no redirect, Stall_F:** buffer←{data, PC}; PC←PC+PC_STEP; go HOLD.
- **RUN, ready=0, no redirect:** no state change.
- **KILL:**
  - A new redirect overwrites pending (priority above).
  - On ready: response discarded; PC←pending (or the new target if a redirect is present that cycle); go RUN.
- **HOLD:**
  - Redirect: buffer discarded; PC←target; go RUN.
  - Else if !Stall_F: IF/ID←{buffer, 1}; go RUN.
- **IF/ID register:**
  - `Flush_D`=1: `valid_D`←0 at the edge. This beats a stall and any delivery. `instr_D`/`pc_D` may update but are don't-care.
  - `Stall_F`=1 and no flush: holds all fields.
  - Otherwise, with no delivery this cycle: `valid_D`←0.
- **Width rule:** PC+PC_STEP wraps modulo 2^N. Targets are used unmodified.

## Timing
- **Reset values:** `imem_req_F`=0, `imem_addr_F`=RESET_PC, `instr_D`=0, `pc_D`=0, `valid_D`=0; state BOOT; buffer and pending cleared.
- **Reset mid-fetch:** the outstanding request is abandoned. Memory must tolerate `req` dropping on reset only.
- **First request:** `imem_req_F`=1 in the first cycle after `reset` deasserts.
- **Throughput:** with zero-latency memory, one instruction per cycle.
- **Latency:** `valid_D` rises at the edge of the ready cycle; IF→D latency is memory latency + 1 edge.
- **Redirect penalty:**
  - Same-cycle ready: the target is requested the next cycle.
  - In KILL: the target is requested the cycle after the stale response.
- **Output timing:** `imem_req_F` and `imem_addr_F` depend only on registered state (no combinational input→output path).

## Structure
- **Package `fetch_pkg`:** state enum `fetch_state_t` {BOOT, RUN, KILL, HOLD} and the default `RESET_PC`/`EXC_VECTOR` constants.
- **Sub-module:** IF/ID register as `if_id_reg` (parametrised N, INSN_W, with enable and clear).
- **PC datapath:** the PC register and incrementer stay inline.

## Test plan
- **Reset, then zero-latency memory returning 0xAA000000+addr:** `valid_D` rises 2 edges after release; `pc_D` follows 0, 4, 8, …; `imem_req_F` remains 1.
- **3-cycle memory latency, `PCSrc_F` pulsed with `PCBranch_F`=0x100 in the second wait cycle:** the stale response is discarded with `valid_D` kept 0; the next request address is 0x100; `pc_D`=0x100 follows.
- **`Exc_F` and `PCSrc_F` asserted in the same cycle:** the redirect goes to 0xD8, not `PCBranch_F`.
- **`Stall_F` high for 3 cycles while ready arrives at addr 0x8:**
  - `imem_req_F` goes low in HOLD and IF/ID holds the 0x4 entry.
  - After release, `pc_D`=0x8 and the next request is 0xC.
- **`Flush_D` together with `Stall_F`:** `valid_D`=0 at the next edge.
- **`RESET_PC`=2^64−4:** the second fetch address wraps to 0. Asserting reset during KILL returns to BOOT with all outputs at their reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        KILL,
        HOLD
    } fetch_state_t;

    localparam logic [63:0] DEFAULT_RESET_PC   = 64'h0;
    localparam logic [63:0] DEFAULT_EXC_VECTOR = 64'hD8;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear drops the valid bit and wins over enable.
module if_id_reg #(
    parameter int unsigned N      = 64,
    parameter int unsigned INSN_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              valid_i,
    input  logic [INSN_W-1:0] instr_i,
    input  logic [N-1:0]      pc_i,
    output logic              valid_o,
    output logic [INSN_W-1:0] instr_o,
    output logic [N-1:0]      pc_o
);

    logic              valid_q, valid_d;
    logic [INSN_W-1:0] instr_q, instr_d;
    logic [N-1:0]      pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (en_i) begin
            valid_d = valid_i;
            instr_d = instr_i;
            pc_d    = pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with req/ready memory handshake, redirect absorption and a
// one-entry park buffer, feeding the IF/ID register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned   N          = 64,
    parameter int unsigned   INSN_W     = 32,
    parameter logic [N-1:0]  RESET_PC   = N'(DEFAULT_RESET_PC),
    parameter logic [N-1:0]  EXC_VECTOR = N'(DEFAULT_EXC_VECTOR),
    parameter int unsigned   PC_STEP    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCSrc_F,
    input  logic [N-1:0]      PCBranch_F,
    input  logic              Exc_F,
    input  logic              Stall_F,
    input  logic              Flush_D,
    output logic              imem_req_F,
    output logic [N-1:0]      imem_addr_F,
    input  logic              imem_ready_F,
    input  logic [INSN_W-1:0] imem_data_F,
    output logic [INSN_W-1:0] instr_D,
    output logic [N-1:0]      pc_D,
    output logic              valid_D
);

    fetch_state_t      state_q, state_d;
    logic [N-1:0]      pc_q, pc_d;
    logic [N-1:0]      pend_q, pend_d;
    logic [INSN_W-1:0] buf_instr_q, buf_instr_d;
    logic [N-1:0]      buf_pc_q, buf_pc_d;

    logic              redirect;
    logic [N-1:0]      target;
    logic [N-1:0]      pc_seq;
    logic              deliver;
    logic [INSN_W-1:0] dlv_instr;
    logic [N-1:0]      dlv_pc;

    assign redirect = Exc_F | PCSrc_F;
    assign target   = Exc_F ? EXC_VECTOR : PCBranch_F;
    assign pc_seq   = pc_q + N'(PC_STEP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            pend_q      <= '0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        deliver     = 1'b0;
        dlv_instr   = imem_data_F;
        dlv_pc      = pc_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect) begin
                    if (imem_ready_F) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = KILL;
                    end
                end else if (imem_ready_F) begin
                    pc_d = pc_seq;
                    if (Stall_F) begin
                        buf_instr_d = imem_data_F;
                        buf_pc_d    = pc_q;
                        state_d     = HOLD;
                    end else begin
                        deliver = 1'b1;
                    end
                end
            end
            KILL: begin
                // The request stays on the old address; its response is dropped.
                if (imem_ready_F) begin
                    pc_d    = redirect ? target : pend_q;
                    state_d = RUN;
                end else if (redirect) begin
                    pend_d = target;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = RUN;
                end else if (!Stall_F) begin
                    deliver   = 1'b1;
                    dlv_instr = buf_instr_q;
                    dlv_pc    = buf_pc_q;
                    state_d   = RUN;
                end
            end
        endcase
    end

    always_comb begin
        imem_req_F  = (state_q == RUN) || (state_q == KILL);
        imem_addr_F = pc_q;
    end

    if_id_reg #(
        .N      (N),
        .INSN_W (INSN_W)
    ) u_if_id (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (!Stall_F),
        .clr_i   (Flush_D),
        .valid_i (deliver),
        .instr_i (dlv_instr),
        .pc_i    (dlv_pc),
        .valid_o (valid_D),
        .instr_o (instr_D),
        .pc_o    (pc_D)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a behavioural fetch model.
module tb_fetch_stage;

    localparam logic [63:0] EXC   = 64'hD8;
    localparam logic [63:0] TOPPC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, PCSrc_F = 1'b0, Exc_F = 1'b0, Stall_F = 1'b0, Flush_D = 1'b0;
    logic [63:0] PCBranch_F = '0;
    logic        imem_ready_F = 1'b0;
    logic [31:0] imem_data_F = '0;
    logic        imem_req_F, valid_D;
    logic [63:0] imem_addr_F, pc_D;
    logic [31:0] instr_D;

    logic        rst2 = 1'b1, src2 = 1'b0, ready2 = 1'b0;
    logic [63:0] br2 = 64'h40;
    logic        req2, valid2;
    logic [63:0] addr2, pc_d2;
    logic [31:0] instr2;

    fetch_stage dut (
        .clk(clk), .reset(reset), .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F), .Exc_F(Exc_F),
        .Stall_F(Stall_F), .Flush_D(Flush_D), .imem_req_F(imem_req_F),
        .imem_addr_F(imem_addr_F), .imem_ready_F(imem_ready_F), .imem_data_F(imem_data_F),
        .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D)
    );

    fetch_stage #(.RESET_PC(TOPPC)) dut_wrap (
        .clk(clk), .reset(rst2), .PCSrc_F(src2), .PCBranch_F(br2), .Exc_F(1'b0),
        .Stall_F(1'b0), .Flush_D(1'b0), .imem_req_F(req2), .imem_addr_F(addr2),
        .imem_ready_F(ready2), .imem_data_F(32'h1234_5678), .instr_D(instr2), .pc_D(pc_d2),
        .valid_D(valid2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: next fetch address, optional pending redirect, optional
    // parked response, and the contents of the decode slot.
    bit          m_boot, m_kill, m_park, m_valid, m_zero, m_req;
    logic [63:0] m_pc, m_pend, m_bp, m_pcd;
    logic [31:0] m_bi, m_instr;

    int lat = 0;
    bit rand_lat = 0;
    int wait_cnt = 0;

    task automatic model_step();
        logic        redir, dlv;
        logic [63:0] tgt, dp;
        logic [31:0] di;
        if (reset) begin
            m_boot = 1; m_kill = 0; m_park = 0; m_valid = 0; m_zero = 1; m_req = 0;
            m_pc = 64'h0; m_pend = '0; m_pcd = '0; m_instr = '0;
            return;
        end
        redir = Exc_F | PCSrc_F;
        tgt   = Exc_F ? EXC : PCBranch_F;
        dlv = 0; di = '0; dp = '0;
        if (m_boot) begin
            m_boot = 0;
        end else if (m_park) begin
            if (redir) begin
                m_park = 0; m_pc = tgt;
            end else if (!Stall_F) begin
                m_park = 0; dlv = 1; di = m_bi; dp = m_bp;
            end
        end else if (m_kill) begin
            if (imem_ready_F) begin
                m_kill = 0; m_pc = redir ? tgt : m_pend;
            end else if (redir) begin
                m_pend = tgt;
            end
        end else if (redir) begin
            if (imem_ready_F) m_pc = tgt;
            else begin m_kill = 1; m_pend = tgt; end
        end else if (imem_ready_F) begin
            if (Stall_F) begin
                m_park = 1; m_bi = imem_data_F; m_bp = m_pc;
            end else begin
                dlv = 1; di = imem_data_F; dp = m_pc;
            end
            m_pc = m_pc + 64'd4;
        end
        if (Flush_D) begin
            m_valid = 0; m_zero = 0;
        end else if (!Stall_F) begin
            m_valid = dlv; m_zero = 0; m_instr = di; m_pcd = dp;
        end
        m_req = !m_boot && !m_park;
    endtask

    task automatic tick();
        @(negedge clk);
        imem_ready_F = m_req && (rand_lat ? ($urandom_range(0, 2) == 0) : (wait_cnt >= lat));
        imem_data_F  = 32'hAA00_0000 + m_pc[31:0];
        check_eq("req", {63'd0, imem_req_F}, {63'd0, m_req});
        check_eq("addr", imem_addr_F, m_pc);
        check_eq("valid_D", {63'd0, valid_D}, {63'd0, m_valid});
        if (m_valid || m_zero) begin
            check_eq("instr_D", {32'd0, instr_D}, {32'd0, m_instr});
            check_eq("pc_D", pc_D, m_pcd);
        end
        @(posedge clk);
        if (m_req) wait_cnt = imem_ready_F ? 0 : wait_cnt + 1;
        model_step();
        if (reset) wait_cnt = 0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1; PCSrc_F = 0; Exc_F = 0; Stall_F = 0; Flush_D = 0;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        // Zero-latency stream from reset.
        rand_lat = 0; lat = 0;
        do_reset();
        tick();
        tick();
        check_eq("a_first_valid", {63'd0, valid_D}, 64'd1);
        check_eq("a_first_pc", pc_D, 64'h0);
        tick();
        check_eq("a_second_pc", pc_D, 64'h4);
        tick();
        check_eq("a_third_pc", pc_D, 64'h8);
        check_eq("a_third_instr", {32'd0, instr_D}, 64'hAA00_0008);
        check_eq("a_req_on", {63'd0, imem_req_F}, 64'd1);

        // Redirect during a 3-cycle wait.
        do_reset();
        lat = 3;
        tick();
        tick();
        PCSrc_F = 1; PCBranch_F = 64'h100;
        tick();
        PCSrc_F = 0;
        tick();
        tick();
        check_eq("b_stale_valid", {63'd0, valid_D}, 64'd0);
        check_eq("b_new_addr", imem_addr_F, 64'h100);
        for (int i = 0; i < 3; i++) tick();
        check_eq("b_wait_valid", {63'd0, valid_D}, 64'd0);
        tick();
        check_eq("b_pc_d", pc_D, 64'h100);
        check_eq("b_instr", {32'd0, instr_D}, 64'hAA00_0100);

        // Stall while the response for 0x8 arrives.
        lat = 0;
        do_reset();
        tick();
        tick();
        tick();
        Stall_F = 1;
        tick();
        tick();
        check_eq("d_hold_req", {63'd0, imem_req_F}, 64'd0);
        check_eq("d_hold_pc", pc_D, 64'h4);
        tick();
        Stall_F = 0;
        tick();
        check_eq("d_rel_pc", pc_D, 64'h8);
        check_eq("d_next_addr", imem_addr_F, 64'hC);

        // Flush beats stall.
        tick();
        Stall_F = 1; Flush_D = 1;
        tick();
        check_eq("e_flush_valid", {63'd0, valid_D}, 64'd0);
        Stall_F = 0; Flush_D = 0;
        tick();

        // Exception outranks branch.
        Exc_F = 1; PCSrc_F = 1; PCBranch_F = 64'h300;
        tick();
        Exc_F = 0; PCSrc_F = 0;
        check_eq("c_exc_addr", imem_addr_F, EXC);
        tick();

        // Randomized traffic.
        rand_lat = 1;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            reset      = ($urandom_range(0, 63) == 0);
            Exc_F      = ($urandom_range(0, 19) == 0);
            PCSrc_F    = ($urandom_range(0, 7) == 0);
            PCBranch_F = {$urandom(), $urandom()};
            Stall_F    = ($urandom_range(0, 3) == 0);
            Flush_D    = ($urandom_range(0, 9) == 0);
            tick();
        end
        reset = 0; Exc_F = 0; PCSrc_F = 0; Stall_F = 0; Flush_D = 0;

        // Wrap at top of address space, then reset while a redirect is absorbed.
        rst2 = 0; ready2 = 1;
        tick();
        check_eq("g_first_addr", addr2, TOPPC);
        check_eq("g_first_req", {63'd0, req2}, 64'd1);
        tick();
        check_eq("g_wrap_addr", addr2, 64'h0);
        check_eq("g_wrap_valid", {63'd0, valid2}, 64'd1);
        check_eq("g_wrap_pc_d", pc_d2, TOPPC);
        check_eq("g_wrap_instr", {32'd0, instr2}, 64'h1234_5678);
        ready2 = 0; src2 = 1;
        tick();
        src2 = 0;
        tick();
        check_eq("g_kill_req", {63'd0, req2}, 64'd1);
        check_eq("g_kill_addr", addr2, 64'h0);
        rst2 = 1;
        tick();
        check_eq("g_rst_req", {63'd0, req2}, 64'd0);
        check_eq("g_rst_addr", addr2, TOPPC);
        check_eq("g_rst_valid", {63'd0, valid2}, 64'd0);
        check_eq("g_rst_instr", {32'd0, instr2}, 64'd0);
        check_eq("g_rst_pc_d", pc_d2, 64'd0);
        rst2 = 0;
        tick();
        check_eq("g_reboot_req", {63'd0, req2}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
